// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the four-digit BCD stopwatch.
package stopwatch_pkg;

   localparam logic [3:0]  DIGIT_MAX      = 4'd9;
   localparam logic [3:0]  DP_PATTERN     = 4'b1101;
   localparam int unsigned TICK_DIV_50MHZ = 5_000_000;

   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_digit.sv
// One up/down BCD digit; cy fires when this digit wraps on an enabled step.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic up,
   output bcd_t q,
   output logic cy
);

   bcd_t q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         if (up) q_d = (q_q == DIGIT_MAX) ? 4'd0 : q_q + 4'd1;
         else    q_d = (q_q == 4'd0) ? DIGIT_MAX : q_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)   q_q <= 4'd0;
      else if (clr) q_q <= 4'd0;
      else          q_q <= q_d;
   end

   assign q  = q_q;
   assign cy = en & (up ? (q_q == DIGIT_MAX) : (q_q == 4'd0));

endmodule

// File: rtl/stopwatch_bcd.sv
// Tenths-of-a-second BCD stopwatch: prescaler, four chained digits, wrap pulse.
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_50MHZ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       clr,
   input  logic       up,
   output bcd_t       d3,
   output bcd_t       d2,
   output bcd_t       d1,
   output bcd_t       d0,
   output logic [3:0] dp_out,
   output logic       ovf
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] p_q, p_d;
   logic          tick;
   logic          ovf_q;
   logic [3:0]    en, cy;
   bcd_t          digit [4];

   always_comb begin
      tick = go && (p_q == P_LAST);
      p_d  = p_q;
      if (go) p_d = tick ? '0 : p_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         p_q   <= '0;
         ovf_q <= 1'b0;
      end else if (clr) begin
         p_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         ovf_q <= cy[3];
      end
   end

   // Ripple enable: a digit steps only when every lower digit wraps this tick.
   assign en = {cy[2:0], tick};

   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .reset (reset),
         .clr   (clr),
         .en    (en[i]),
         .up    (up),
         .q     (digit[i]),
         .cy    (cy[i])
      );
   end

   assign d0     = digit[0];
   assign d1     = digit[1];
   assign d2     = digit[2];
   assign d3     = digit[3];
   assign ovf    = ovf_q;
   assign dp_out = DP_PATTERN;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench: a tenths-count model predicts each cycle, a monitor compares.
module tb_stopwatch_bcd;

   localparam int unsigned TD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0, go = 1'b0, clr = 1'b0, up = 1'b1;
   logic [3:0] d3, d2, d1, d0, dp_out;
   logic       ovf;

   stopwatch_bcd #(.TICK_DIV(TD)) dut (
      .clk    (clk),
      .reset  (reset),
      .go     (go),
      .clr    (clr),
      .up     (up),
      .d3     (d3),
      .d2     (d2),
      .d1     (d1),
      .d0     (d0),
      .dp_out (dp_out),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;
      logic        ovf;
   } exp_t;

   exp_t q_exp[$];
   int   tests = 0, fails = 0, cyc = 0;
   bit   done = 1'b0;

   // Reference model: elapsed tenths as an integer, cycles since the last step.
   int   m_val = 0, m_cnt = 0;
   bit   m_ovf = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic cycle(input logic r, input logic c, input logic g, input logic u);
      exp_t e;
      reset = r; clr = c; go = g; up = u;
      m_ovf = 1'b0;
      if (!r || c) begin
         m_val = 0;
         m_cnt = 0;
      end else if (g) begin
         m_cnt++;
         if (m_cnt == TD) begin
            m_cnt = 0;
            if (u) begin
               m_ovf = (m_val == 9999);
               m_val = (m_val + 1) % 10000;
            end else begin
               m_ovf = (m_val == 0);
               m_val = (m_val + 9999) % 10000;
            end
         end
      end
      e.digits = to_bcd(m_val);
      e.ovf    = m_ovf;
      q_exp.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic run(input int n, input logic g, input logic u);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, g, u);
   endtask

   // Monitor: every cycle the DUT presents a new registered value.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         tests++;
         if (dp_out !== 4'b1101) begin
            fails++;
            $display("FAIL dp_out cycle %0d got %b required 1101", cyc, dp_out);
         end
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            tests += 2;
            if ({d3, d2, d1, d0} !== e.digits) begin
               fails++;
               $display("FAIL digits cycle %0d got %h required %h", cyc,
                        {d3, d2, d1, d0}, e.digits);
            end
            if (ovf !== e.ovf) begin
               fails++;
               $display("FAIL ovf cycle %0d got %b required %b", cyc, ovf, e.ovf);
            end
         end
      end
   end

   initial begin
      #1;
      tests++;
      if (dp_out !== 4'b1101) begin
         fails++;
         $display("FAIL dp_out_in_reset got %b required 1101", dp_out);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      run(9, 1'b1, 1'b1);                     // 000.1 at edge 4, 000.2 at edge 8
      run(4 * 8, 1'b1, 1'b1);                 // through 000.9 -> 001.0
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      run(4, 1'b1, 1'b0);                     // 000.0 -> 999.9 wrap down
      run(4, 1'b1, 1'b1);                     // 999.9 -> 000.0 wrap up
      run(4 * 100, 1'b1, 1'b1);               // reach 010.0
      run(4, 1'b1, 1'b0);                     // 010.0 -> 009.9
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      run(2, 1'b1, 1'b1);                     // p = 2
      run(10, 1'b0, 1'b1);                    // pause
      run(6, 1'b1, 1'b1);
      // Toggle up between ticks: only the tick-edge value matters.
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, 1'(i % 2));
      // Clear exactly on a tick cycle, then restart.
      while (m_cnt != TD - 1) run(1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      run(6, 1'b1, 1'b1);
      // Reset mid-period.
      run(3, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      run(6, 1'b1, 1'b1);
      // Randomized phase.
      for (int i = 0; i < 4000; i++) begin
         logic r, c, g, u;
         r = ($urandom_range(199) != 0);
         c = ($urandom_range(99) == 0);
         g = ($urandom_range(9) != 0);
         u = (i / 500) % 2 == 0 ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
         cycle(r, c, g, u);
      end
      @(posedge clk);
      #2;
      tests++;
      if (q_exp.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending required 0", q_exp.size());
      end
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      if (!done) begin
         $display("FAIL timeout got running required finished");
         $fatal(1, "timeout");
      end
   end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit BCD stopwatch counting tenths of a second, 000.0 to 999.9, up or down. Drives the hex-digit and decimal-point inputs of the board's four-digit seven-segment multiplexer directly: `d3`..`d0` map to `hex3`..`hex0`, and `dp_out` maps to `dp_in`. A prescaler turns the 50 MHz system clock into a 0.1 s count enable.

## Interface
- `TICK_DIV`, 5_000_000: clock cycles per count step (0.1 s at 50 MHz); legal range ≥ 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `go`  input  1  level; 1 = run, 0 = pause (prescaler and digits hold).
- `clr`  input  1  synchronous clear; level-sensitive, active high.
- `up`  input  1  count direction; 1 = up, 0 = down.
- `d3`, `d2`, `d1`, `d0`  output  4 each  BCD digits: hundreds, tens, units of seconds, tenths; registered.
- `dp_out`  output  4  active-low decimal points; constant 4'b1101 (point lit after `d1`).
- `ovf`  output  1  one-cycle pulse on wrap-around; registered.

## Operation
- Priority each edge: `reset` = 0 > `clr` = 1 > counting > hold.
- Reset and clear set the prescaler, all digits and `ovf` to 0; `dp_out` = 4'b1101 at all times, including during reset.
- Prescaler `p`, width $clog2(TICK_DIV):
  - When `go` = 1, `p` increments every cycle.
  - At `p` = TICK_DIV-1 with `go` = 1, internal `tick` = 1 and `p` returns to 0.
  - When `go` = 0, `p` holds.
- On `tick`, the digit chain steps once in direction `up`:
  - Up: `d0` 9→0 carries into `d1`, and likewise through `d3`. 999.9 → 000.0 with `ovf` = 1.
  - Down: `d0` 0→9 borrows from `d1`, and likewise upward. 000.0 → 999.9 with `ovf` = 1.
  - All four digits update on the same edge; no intermediate values are visible.
- Digits never leave 0–9. Non-BCD values are unreachable and need no handling.
- `up` is sampled only on `tick` edges. Toggling `up` between ticks has no effect until the next tick and does not disturb `p`.
- `ovf` is 1 only in the cycle after a wrapping tick, i.e. while the wrapped value is first visible. Otherwise 0.

## Timing
- Latency: `tick` is combinational from `p` and `go`. The new digit value is visible one cycle after the `tick` cycle.
- From reset release with `go` held at 1, the first increment is visible after exactly TICK_DIV rising edges.
- Pausing: `go` dropped at `p` = k and raised later resumes at `p` = k. The period is stretched by the paused cycles, with no lost or extra tick.
- `clr` and `tick` in the same cycle: clear wins; the digits read 000.0 and `ovf` = 0.
- `clr` held high: the counter stays at 000.0 regardless of `go`. Counting starts on the first cycle after `clr` falls, if `go` = 1.
- Reset asserted mid-period or mid-carry: all state returns to reset values on that edge. No partial update survives.
- The inputs are synchronous to `clk`. Debouncing and synchronisation of buttons are external.

## Structure
- Package `stopwatch_pkg`:
  - `DIGIT_MAX` = 4'd9
  - `DP_PATTERN` = 4'b1101
  - `TICK_DIV_50MHZ` = 5_000_000
  - typedef `bcd_t` (4-bit)
- Sub-module `bcd_digit`:
  - Inputs: `clk`, `reset`, `clr`, `en`, `up`.
  - Outputs: `q` (`bcd_t`), `cy` (combinational carry/borrow: `en` & (`up` ? `q`=9 : `q`=0)).
  - Four instances are chained `en_{i+1}` = `cy_i`, with `en_0` = `tick`.
  - `ovf` is the registered `cy_3`.
- The top level holds the prescaler, the chain wiring, `ovf` and `dp_out`.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset 3 cycles, then `go` = 1, `up` = 1: digits 000.0 until edge 4, 000.1 at edge 4, 000.2 at edge 8. `dp_out` = 4'b1101 throughout.
- Run up from 000.9: next tick gives 001.0. Run up from 999.9: next tick gives 000.0, with `ovf` = 1 for exactly one cycle.
- `up` = 0 from 010.0: next tick gives 009.9. From 000.0: next tick gives 999.9 with an `ovf` pulse.
- `go` = 0 for 10 cycles at `p` = 2, then `go` = 1: the next step comes 2 cycles later. The digits are unchanged during the pause.
- `clr` asserted in a tick cycle at 123.4: 000.0 next cycle, `ovf` = 0. With `go` = 1 and `clr` low, 000.1 follows 4 cycles later.
- `reset` = 0 mid-period at 456.7 with `p` = 3: the next cycle shows 000.0, `p` = 0, `ovf` = 0.
